int_multiply_stream: RTL

Pipelined, handshaked successor to the combinational signed integer multiplier. It computes a full-precision signed product a*b and arithmetically right-shifts it by SHIFT with round-half-up. It then saturates to OUT_WIDTH and reports overflow. It sits between streaming operand sources and downstream accumulators in the quantised matmul datapath, and sustains one product per clock under a valid/ready handshake with full backpressure.

---
 rtl/int_multiply_stream.sv | 131 +++++++++++++
 1 files changed

// File: rtl/int_multiply_stream.sv
// Two-stage streaming signed multiplier with round-half-up shift and saturation.
// Valid/ready on both sides, full backpressure, one result per clock.
module int_multiply_stream #(
    parameter int A_WIDTH   = 8,
    parameter int B_WIDTH   = 8,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [A_WIDTH-1:0]   data_in_a,
    input  logic signed [B_WIDTH-1:0]   data_in_b,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        data_out_sat,
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    localparam int P   = A_WIDTH + B_WIDTH;
    localparam int PAD = P - OUT_WIDTH + 2;

    localparam logic signed [P:0] OUT_MAX =
        {{PAD{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [P:0] OUT_MIN =
        {{PAD{1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic adv1;
    logic adv2;

    logic                s1_valid_q;
    logic                s1_valid_d;
    logic signed [P-1:0] prod_q;
    logic signed [P-1:0] prod_d;

    logic signed [OUT_WIDTH-1:0] out_q;
    logic signed [OUT_WIDTH-1:0] out_d;
    logic                        sat_q;
    logic                        sat_d;
    logic                        out_valid_q;
    logic                        out_valid_d;

    logic signed [P-1:0] a_ext;
    logic signed [P-1:0] b_ext;
    logic signed [P:0]   rnd_res;

    logic                        over;
    logic                        under;
    logic signed [OUT_WIDTH-1:0] clamp_val;
    logic                        clamp_sat;

    assign adv2          = !out_valid_q || data_out_ready;
    assign adv1          = !s1_valid_q || adv2;
    assign data_in_ready = adv1;

    assign data_out       = out_q;
    assign data_out_sat   = sat_q;
    assign data_out_valid = out_valid_q;

    assign a_ext = {{B_WIDTH{data_in_a[A_WIDTH-1]}}, data_in_a};
    assign b_ext = {{A_WIDTH{data_in_b[B_WIDTH-1]}}, data_in_b};

    // One guard bit above the product keeps the rounding add from wrapping.
    generate
        if (SHIFT == 0) begin : g_noshift
            assign rnd_res = {prod_q[P-1], prod_q};
        end else begin : g_shift
            localparam logic [P:0] HALF =
                {{P{1'b0}}, 1'b1} << (SHIFT - 1);
            logic signed [P:0] rnd_sum;
            assign rnd_sum = {prod_q[P-1], prod_q} + $signed(HALF);
            assign rnd_res = rnd_sum >>> SHIFT;
        end
    endgenerate

    always_comb begin
        over      = rnd_res > OUT_MAX;
        under     = rnd_res < OUT_MIN;
        clamp_val = rnd_res[OUT_WIDTH-1:0];
        clamp_sat = 1'b0;
        unique case (1'b1)
            over: begin
                clamp_val = OUT_MAX[OUT_WIDTH-1:0];
                clamp_sat = 1'b1;
            end
            under: begin
                clamp_val = OUT_MIN[OUT_WIDTH-1:0];
                clamp_sat = 1'b1;
            end
            default: begin
                clamp_val = rnd_res[OUT_WIDTH-1:0];
                clamp_sat = 1'b0;
            end
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        prod_d      = prod_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        sat_d       = sat_q;
        if (adv1) begin
            s1_valid_d = data_in_valid;
            prod_d     = a_ext * b_ext;
        end
        if (adv2) begin
            out_valid_d = s1_valid_q;
            out_d       = clamp_val;
            sat_d       = clamp_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            sat_q       <= sat_d;
        end
    end

endmodule
